// File: rtl/period_meter_mc.sv
// Multi-channel period meter: each channel synchronises and debounces its input,
// then measures the cycle count between filtered rising edges with a timeout.

module period_meter_mc_filt #(
  parameter int FILT_LEN = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_raw,
  output logic edge_p
);

  localparam int RC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [RC_W-1:0] RUN_MAX = RC_W'(FILT_LEN - 1);
  localparam logic [RC_W-1:0] RUN_ONE = RC_W'(1);

  logic            sync1;
  logic            sync2;
  logic            filt;
  logic            filt_d;
  logic [RC_W-1:0] run_cnt;

  // The edge pulse is registered so every channel sees the same fixed latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      filt    <= 1'b0;
      filt_d  <= 1'b0;
      edge_p  <= 1'b0;
      run_cnt <= '0;
    end else begin
      sync1  <= sig_raw;
      sync2  <= sync1;
      filt_d <= filt;
      edge_p <= filt & ~filt_d;
      if (sync2 == filt) begin
        run_cnt <= '0;
      end else if (run_cnt == RUN_MAX) begin
        filt    <= sync2;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + RUN_ONE;
      end
    end
  end

endmodule

// state   | meaning
// IDLE    | disabled or waiting for the first edge; counter held at 0
// MEASURE | window open; counting cycles since last edge or timeout
module period_meter_mc_ch #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 400000000,
  parameter int RST_VAL = 20000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             edge_p,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             tout
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] PER_RST = CNT_W'(RST_VAL);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] per_q;
  logic [CNT_W-1:0] per_nxt;
  logic             tout_q;
  logic             tout_nxt;
  logic             valid_q;
  logic             valid_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      per_q   <= PER_RST;
      tout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      per_q   <= per_nxt;
      tout_q  <= tout_nxt;
      valid_q <= valid_nxt;
    end
  end

  // cnt equals the cycles elapsed since the window opened, so it is the period
  // directly when the closing edge arrives; an edge beats a coincident timeout.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    per_nxt   = per_q;
    tout_nxt  = tout_q;
    valid_nxt = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (edge_p) begin
            state_nxt = MEASURE;
            cnt_nxt   = CNT_ONE;
          end
        end
        MEASURE: begin
          if (edge_p) begin
            per_nxt   = cnt;
            tout_nxt  = 1'b0;
            valid_nxt = 1'b1;
            cnt_nxt   = CNT_ONE;
          end else if (cnt >= CNT_LIM) begin
            per_nxt   = '0;
            tout_nxt  = 1'b1;
            valid_nxt = 1'b1;
            cnt_nxt   = CNT_ONE;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign period = per_q;
  assign valid  = valid_q;
  assign tout   = tout_q;

endmodule

module period_meter_mc #(
  parameter int NCH      = 4,
  parameter int CNT_W    = 32,
  parameter int FILT_LEN = 100,
  parameter int TIMEOUT  = 400000000,
  parameter int RST_VAL  = 20000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       sig_in,
  input  logic [NCH-1:0]       en,
  output logic [NCH*CNT_W-1:0] period_out,
  output logic [NCH-1:0]       valid,
  output logic [NCH-1:0]       tout
);

  logic [NCH-1:0] edge_p;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    period_meter_mc_filt #(
      .FILT_LEN(FILT_LEN)
    ) u_filt (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_raw(sig_in[g]),
      .edge_p (edge_p[g])
    );

    period_meter_mc_ch #(
      .CNT_W  (CNT_W),
      .TIMEOUT(TIMEOUT),
      .RST_VAL(RST_VAL)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en[g]),
      .edge_p(edge_p[g]),
      .period(period_out[g*CNT_W +: CNT_W]),
      .valid (valid[g]),
      .tout  (tout[g])
    );
  end

endmodule

// File: tb/tb_period_meter_mc.sv
// Directed bench for period_meter_mc: reset, periods, glitch filter, timeout,
// edge/timeout boundary, enable abort and multi-channel alignment.

module tb_period_meter_mc;

  localparam int NCH = 4;
  localparam int CW  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    sig_in;
  logic [NCH-1:0]    en;
  logic [NCH*CW-1:0] period_out;
  logic [NCH-1:0]    valid;
  logic [NCH-1:0]    tout;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int             vcount    [NCH];
  int             last_vcyc [NCH];
  int             prev_vcyc [NCH];
  logic [CW-1:0]  last_per  [NCH];
  logic           last_tout [NCH];
  logic [NCH-1:0] last_vmask;
  logic [NCH-1:0] valid_prev;
  logic           dbl_valid;
  int             base      [NCH];

  period_meter_mc #(
    .NCH(NCH), .CNT_W(CW), .FILT_LEN(4), .TIMEOUT(1000), .RST_VAL(500)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .en        (en),
    .period_out(period_out),
    .valid     (valid),
    .tout      (tout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < NCH; i++) begin
      vcount[i] = 0; last_vcyc[i] = 0; prev_vcyc[i] = 0;
      last_per[i] = '0; last_tout[i] = 1'b0;
    end
    last_vmask = '0;
    valid_prev = '0;
    dbl_valid  = 1'b0;
  end

  always @(negedge clk) begin
    valid_prev <= valid;
    if ((valid & valid_prev) != '0) dbl_valid <= 1'b1;
    if (valid != '0) last_vmask <= valid;
    for (int i = 0; i < NCH; i++) begin
      if (valid[i]) begin
        vcount[i]    <= vcount[i] + 1;
        prev_vcyc[i] <= last_vcyc[i];
        last_vcyc[i] <= cyc;
        last_per[i]  <= period_out[i*CW +: CW];
        last_tout[i] <= tout[i];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic [NCH-1:0] mask, input int hi, input int lo);
    sig_in = sig_in | mask;
    repeat (hi) @(negedge clk);
    sig_in = sig_in & ~mask;
    repeat (lo) @(negedge clk);
  endtask

  task automatic snap();
    for (int i = 0; i < NCH; i++) base[i] = vcount[i];
  endtask

  function automatic int delta(input int i);
    return vcount[i] - base[i];
  endfunction

  function automatic logic [CW-1:0] per_of(input int i);
    return period_out[i*CW +: CW];
  endfunction

  initial begin
    rst_n  = 1'b0;
    sig_in = '0;
    en     = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NCH; i++) chk($sformatf("rst_per%0d", i), per_of(i), 500);
    chk("rst_valid", valid, 0);
    chk("rst_tout", tout, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // identical 200-cycle square wave on all channels
    en = 4'hf;
    snap();
    repeat (4) pulse(4'hf, 100, 100);
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("sq_cnt%0d", i), delta(i), 3);
      chk($sformatf("sq_per%0d", i), last_per[i], 200);
    end
    chk("sq_tout0", last_tout[0], 0);
    chk("sq_mask", last_vmask, 4'hf);
    chk("sq_spacing0", last_vcyc[0] - prev_vcyc[0], 200);
    en = '0;
    repeat (5) @(negedge clk);

    // ch1: 300-cycle period with 3-cycle glitches in the low phase
    en = 4'b0010;
    snap();
    repeat (3) begin
      pulse(4'b0010, 100, 50);
      pulse(4'b0010, 3, 147);
    end
    pulse(4'b0010, 100, 100);
    chk("glitch_cnt", delta(1), 3);
    chk("glitch_per", last_per[1], 300);
    pulse(4'b0010, 4, 20);
    chk("pulse4_cnt", delta(1), 4);
    chk("pulse4_per", last_per[1], 200);
    repeat (76) @(negedge clk);
    pulse(4'b0010, 100, 20);
    chk("after4_per", last_per[1], 100);
    en = '0;
    repeat (5) @(negedge clk);

    // ch2: stop toggling -> timeouts every 1000, then restore
    en = 4'b0100;
    snap();
    pulse(4'b0100, 100, 2400);
    chk("to_cnt", delta(2), 2);
    chk("to_per", last_per[2], 0);
    chk("to_flag", last_tout[2], 1);
    chk("to_spacing", last_vcyc[2] - prev_vcyc[2], 1000);
    pulse(4'b0100, 100, 150);
    pulse(4'b0100, 20, 0);
    chk("restore_per", last_per[2], 250);
    chk("restore_tout", last_tout[2], 0);
    chk("restore_tout_out", tout[2], 0);
    sig_in = '0;
    en = '0;
    repeat (5) @(negedge clk);

    // ch3: edge exactly at window cycle 1000, then enable drop mid-window
    en = 4'b1000;
    snap();
    pulse(4'b1000, 100, 900);
    pulse(4'b1000, 20, 0);
    chk("bnd_cnt", delta(3), 1);
    chk("bnd_per", last_per[3], 1000);
    chk("bnd_tout", last_tout[3], 0);
    pulse(4'b1000, 80, 200);
    en = '0;
    snap();
    repeat (1500) @(negedge clk);
    chk("abort_cnt", delta(3), 0);
    chk("abort_per", per_of(3), 1000);
    chk("abort_tout", tout[3], 0);
    repeat (5) @(negedge clk);

    // asynchronous reset in the middle of a window
    en = 4'hf;
    pulse(4'hf, 100, 100);
    pulse(4'hf, 50, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_per", period_out, {4{16'd500}});
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_tout", tout, 0);
    repeat (5) @(negedge clk);
    chk("hold_rst_per", period_out, {4{16'd500}});
    chk("hold_rst_valid", valid, 0);
    rst_n = 1'b1;
    snap();
    repeat (20) @(negedge clk);
    pulse(4'hf, 100, 100);
    chk("post_rst_first", delta(0) + delta(1) + delta(2) + delta(3), 0);
    pulse(4'hf, 20, 0);
    chk("post_rst_cnt", delta(0) + delta(1) + delta(2) + delta(3), 4);
    chk("post_rst_per", period_out, {4{16'd200}});
    sig_in = '0;
    en = '0;
    repeat (5) @(negedge clk);

    chk("no_dbl_valid", dbl_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
